fft_frame_ctrl: RTL and testbench

- Frame-level scheduler for the 32-point SDF DIF FFT core.
- Arbitrates two sample-stream requesters round-robin and feeds exactly one 32-sample frame per grant into the core.
- Counts the 32 ordered output samples and tags each with source and bin index.
- Re-arms the one-shot core by pulsing its active-low reset between frames; a drain watchdog recovers from a hung core.

---
 rtl/fft_ctrl_pkg.sv | 15 +
 rtl/fft_frame_ctrl_if.sv | 52 +++++
 rtl/fft_frame_ctrl_rr_arb2.sv | 34 +++
 rtl/fft_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared constants for the FFT frame controller: sample widths, default frame size and the
// controller state encoding.
package fft_ctrl_pkg;

  localparam int unsigned DIN_W    = 12;
  localparam int unsigned DOUT_W   = 16;
  localparam int unsigned N_PT_DEF = 32;
  localparam int unsigned CW       = $clog2(N_PT_DEF);

  localparam logic [1:0] StRearm = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StFeed  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Signal bundle between the frame controller, its two sample requesters, the FFT core and the
// result sink. master is the controller's view, slave the environment's.
interface fft_frame_ctrl_if #(
  parameter int unsigned N_PT = 32
) ();
  import fft_ctrl_pkg::*;

  localparam int unsigned IdxW = $clog2(N_PT);

  logic                     s0_valid;
  logic                     s0_ready;
  logic signed [DIN_W-1:0]  s0_r;
  logic signed [DIN_W-1:0]  s0_i;
  logic                     s1_valid;
  logic                     s1_ready;
  logic signed [DIN_W-1:0]  s1_r;
  logic signed [DIN_W-1:0]  s1_i;

  logic                     fft_rst_n;
  logic                     fft_in_valid;
  logic signed [DIN_W-1:0]  fft_din_r;
  logic signed [DIN_W-1:0]  fft_din_i;
  logic                     fft_out_valid;
  logic signed [DOUT_W-1:0] fft_dout_r;
  logic signed [DOUT_W-1:0] fft_dout_i;

  logic                     m_valid;
  logic signed [DOUT_W-1:0] m_r;
  logic signed [DOUT_W-1:0] m_i;
  logic                     m_src;
  logic [IdxW-1:0]          m_idx;
  logic                     m_last;
  logic                     busy;
  logic                     err_timeout;

  modport master (
    input  s0_valid, s0_r, s0_i, s1_valid, s1_r, s1_i,
    input  fft_out_valid, fft_dout_r, fft_dout_i,
    output s0_ready, s1_ready,
    output fft_rst_n, fft_in_valid, fft_din_r, fft_din_i,
    output m_valid, m_r, m_i, m_src, m_idx, m_last, busy, err_timeout
  );

  modport slave (
    output s0_valid, s0_r, s0_i, s1_valid, s1_r, s1_i,
    output fft_out_valid, fft_dout_r, fft_dout_i,
    input  s0_ready, s1_ready,
    input  fft_rst_n, fft_in_valid, fft_din_r, fft_din_i,
    input  m_valid, m_r, m_i, m_src, m_idx, m_last, busy, err_timeout
  );

endinterface

// File: rtl/fft_frame_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: grant is combinational from req and the pointer; the pointer moves
// to the losing side whenever a grant is taken (advance).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic       gnt_valid
);

  logic rr_ptr_q;

  assign gnt_valid = |req;

  always_comb begin
    grant = 1'b0;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = rr_ptr_q;
      default: grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (advance) begin
      rr_ptr_q <= ~grant;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame scheduler for the one-shot 32-point FFT core: grants one requester per frame, feeds
// N_PT samples, tags N_PT results, then pulses the core reset before the next frame.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned N_PT      = 32,
  parameter int unsigned REARM_CYC = 2,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic             clk,
  input  logic             rst,
  fft_frame_ctrl_if.master bus
);

  localparam int unsigned IdxW = $clog2(N_PT);
  localparam int unsigned RW   = $clog2(REARM_CYC + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_PT - 1);

  logic [1:0]               state_q, state_d;
  logic                     grant_q;
  logic [IdxW-1:0]          in_cnt_q, out_cnt_q;
  logic [RW-1:0]            rearm_cnt_q;
  logic [TW-1:0]            wd_cnt_q;
  logic                     fft_rst_n_q, fft_in_valid_q;
  logic signed [DIN_W-1:0]  din_r_q, din_i_q;
  logic                     m_valid_q, m_src_q, m_last_q, busy_q, err_q;
  logic signed [DOUT_W-1:0] m_r_q, m_i_q;
  logic [IdxW-1:0]          m_idx_q;

  logic       arb_grant, arb_valid, advance;
  logic       feeding, accept, in_last, out_take, out_last, wd_expire;
  logic [1:0] req;

  assign req     = {bus.s1_valid, bus.s0_valid};
  assign advance = (state_q == StIdle) && arb_valid;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (advance),
    .grant     (arb_grant),
    .gnt_valid (arb_valid)
  );

  assign feeding      = (state_q == StFeed);
  assign bus.s0_ready = feeding && !grant_q && bus.s0_valid;
  assign bus.s1_ready = feeding && grant_q && bus.s1_valid;
  assign accept       = bus.s0_ready || bus.s1_ready;
  assign in_last      = accept && (in_cnt_q == LastIdx);
  assign out_take     = (state_q == StDrain) && bus.fft_out_valid;
  assign out_last     = out_take && (out_cnt_q == LastIdx);
  // Watchdog only guards the wait for the first result; a started frame always completes.
  assign wd_expire    = (state_q == StDrain) && !bus.fft_out_valid && (out_cnt_q == '0) &&
                        (wd_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRearm: if (rearm_cnt_q == RW'(1)) state_d = StIdle;
      StIdle:  if (arb_valid) state_d = StFeed;
      StFeed:  if (in_last) state_d = StDrain;
      StDrain: if (out_last || wd_expire) state_d = StRearm;
      default: state_d = StRearm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRearm;
      rearm_cnt_q    <= RW'(REARM_CYC);
      grant_q        <= 1'b0;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      wd_cnt_q       <= '0;
      fft_rst_n_q    <= 1'b0;
      fft_in_valid_q <= 1'b0;
      din_r_q        <= '0;
      din_i_q        <= '0;
      m_valid_q      <= 1'b0;
      m_r_q          <= '0;
      m_i_q          <= '0;
      m_src_q        <= 1'b0;
      m_idx_q        <= '0;
      m_last_q       <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= (state_d != StIdle);
      fft_in_valid_q <= accept;
      m_valid_q      <= out_take;
      m_last_q       <= out_last;

      if (advance) grant_q <= arb_grant;

      if (accept) begin
        din_r_q  <= grant_q ? bus.s1_r : bus.s0_r;
        din_i_q  <= grant_q ? bus.s1_i : bus.s0_i;
        in_cnt_q <= in_last ? '0 : in_cnt_q + 1'b1;
      end

      if (in_last) begin
        out_cnt_q <= '0;
        wd_cnt_q  <= '0;
      end

      if (out_take) begin
        m_r_q     <= bus.fft_dout_r;
        m_i_q     <= bus.fft_dout_i;
        m_src_q   <= grant_q;
        m_idx_q   <= out_cnt_q;
        out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
      end else if ((state_q == StDrain) && (out_cnt_q == '0)) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end

      if (wd_expire) err_q <= 1'b1;

      if (state_q == StRearm) begin
        rearm_cnt_q <= rearm_cnt_q - 1'b1;
        if (state_d == StIdle) fft_rst_n_q <= 1'b1;
      end

      if ((state_q == StDrain) && (state_d == StRearm)) begin
        fft_rst_n_q <= 1'b0;
        rearm_cnt_q <= RW'(REARM_CYC);
      end
    end
  end

  assign bus.fft_rst_n    = fft_rst_n_q;
  assign bus.fft_in_valid = fft_in_valid_q;
  assign bus.fft_din_r    = din_r_q;
  assign bus.fft_din_i    = din_i_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_r          = m_r_q;
  assign bus.m_i          = m_i_q;
  assign bus.m_src        = m_src_q;
  assign bus.m_idx        = m_idx_q;
  assign bus.m_last       = m_last_q;
  assign bus.busy         = busy_q;
  assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: random sample frames, a behavioural DFT core model and a frame-level
// arbitration/result model.
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  localparam int N     = 32;
  localparam int REARM = 2;
  localparam int TMO   = 256;
  localparam int IW    = $clog2(N);
  localparam real PI   = 3.14159265358979323846;

  typedef struct packed {
    logic signed [15:0] r;
    logic signed [15:0] i;
    logic               src;
    logic [IW-1:0]      idx;
    logic               last;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.N_PT(N)) bus ();

  fft_frame_ctrl #(.N_PT(N), .REARM_CYC(REARM), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] sq0[$], sq1[$];   // samples still to be offered
  logic [23:0] fq0[$], fq1[$];   // same samples, staged for the model
  out_t exp_q[$], out_q[$];
  int   exp_acc[$], acc_src_q[$];
  bit   tr_rstn[$], tr_inval[$], tr_acc[$], tr_mv[$], tr_err[$], tr_last[$];
  bit   m_rr = 1'b0;
  bit   core_hang = 1'b0;
  bit   timed_out;
  int   gap_every = 0;
  int   stop_acc = 0;

  int ref_r[N], ref_i[N], cbuf_r[N], cbuf_i[N];
  int c_in = 0, c_lat = 0, c_k = 0;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Bin k of the forward DFT of either the model frame or the core's captured frame.
  function automatic int dft(input bit core, input int k, input bit im);
    real acc = 0.0;
    real ang, xr, xi;
    for (int n = 0; n < N; n++) begin
      xr  = core ? real'(cbuf_r[n]) : real'(ref_r[n]);
      xi  = core ? real'(cbuf_i[n]) : real'(ref_i[n]);
      ang = -2.0 * PI * real'((n * k) % N) / real'(N);
      acc += im ? (xr * $sin(ang) + xi * $cos(ang)) : (xr * $cos(ang) - xi * $sin(ang));
    end
    return rnd(acc);
  endfunction

  // One-shot core model: collects N inputs, waits a few cycles, then holds out_valid high.
  always @(posedge clk) begin
    if (bus.fft_rst_n !== 1'b1) begin
      c_in <= 0; c_lat <= 0; c_k <= 0;
      bus.fft_out_valid <= 1'b0;
      bus.fft_dout_r    <= '0;
      bus.fft_dout_i    <= '0;
    end else begin
      if (bus.fft_in_valid && c_in < N) begin
        cbuf_r[c_in] <= int'(bus.fft_din_r);
        cbuf_i[c_in] <= int'(bus.fft_din_i);
        c_in <= c_in + 1;
      end
      if (c_in == N && !core_hang) begin
        if (c_lat < 3) c_lat <= c_lat + 1;
        else begin
          bus.fft_out_valid <= 1'b1;
          if (c_k < N) begin
            bus.fft_dout_r <= 16'(dft(1'b1, c_k, 1'b0));
            bus.fft_dout_i <= 16'(dft(1'b1, c_k, 1'b1));
            c_k <= c_k + 1;
          end else begin
            bus.fft_dout_r <= '0;
            bus.fft_dout_i <= '0;
          end
        end
      end
    end
  end

  task automatic load(input int src, input int nframes, input bit dc);
    logic [23:0] s;
    for (int f = 0; f < nframes * N; f++) begin
      if (dc) s = {12'sd100, 12'sd0};
      else s = {12'(int'($urandom_range(800)) - 400), 12'(int'($urandom_range(800)) - 400)};
      if (src == 0) begin sq0.push_back(s); fq0.push_back(s); end
      else begin sq1.push_back(s); fq1.push_back(s); end
    end
  endtask

  // Round-robin frame model: owner of each frame and its N tagged DFT bins.
  task automatic build_expected();
    int owner;
    logic [23:0] s;
    exp_q.delete(); exp_acc.delete();
    while (fq0.size() > 0 || fq1.size() > 0) begin
      if (fq0.size() > 0 && fq1.size() > 0) owner = int'(m_rr);
      else owner = (fq0.size() > 0) ? 0 : 1;
      m_rr = (owner == 0);
      for (int n = 0; n < N; n++) begin
        s = (owner == 0) ? fq0.pop_front() : fq1.pop_front();
        ref_r[n] = int'($signed(s[23:12]));
        ref_i[n] = int'($signed(s[11:0]));
        exp_acc.push_back(owner);
      end
      for (int k = 0; k < N; k++)
        exp_q.push_back('{r: 16'(dft(1'b0, k, 1'b0)), i: 16'(dft(1'b0, k, 1'b1)),
                          src: owner[0], idx: IW'(k), last: (k == N - 1)});
    end
  endtask

  task automatic run(input int max_cyc);
    int cyc = 0;
    int nacc = 0;
    bit a0, a1;
    out_q.delete(); acc_src_q.delete();
    tr_rstn.delete(); tr_inval.delete(); tr_acc.delete();
    tr_mv.delete(); tr_err.delete(); tr_last.delete();
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      tr_rstn.push_back(bus.fft_rst_n);
      tr_inval.push_back(bus.fft_in_valid);
      tr_mv.push_back(bus.m_valid);
      tr_err.push_back(bus.err_timeout);
      tr_last.push_back(bus.m_last);
      if (bus.m_valid)
        out_q.push_back('{r: bus.m_r, i: bus.m_i, src: bus.m_src, idx: bus.m_idx,
                          last: bus.m_last});
      if (cyc > 2 && sq0.size() == 0 && sq1.size() == 0 && !bus.busy) break;
      if (stop_acc > 0 && nacc == stop_acc) break;
      if (cyc >= max_cyc) begin timed_out = 1'b1; break; end
      bus.s0_valid = (sq0.size() > 0);
      if (sq0.size() > 0) begin bus.s0_r = sq0[0][23:12]; bus.s0_i = sq0[0][11:0]; end
      bus.s1_valid = (sq1.size() > 0) && !(gap_every > 0 && (cyc % gap_every) == gap_every - 1);
      if (sq1.size() > 0) begin bus.s1_r = sq1[0][23:12]; bus.s1_i = sq1[0][11:0]; end
      #1;
      a0 = bus.s0_valid && bus.s0_ready;
      a1 = bus.s1_valid && bus.s1_ready;
      if (a0) begin acc_src_q.push_back(0); void'(sq0.pop_front()); end
      if (a1) begin acc_src_q.push_back(1); void'(sq1.pop_front()); end
      tr_acc.push_back(a0 || a1);
      if (a0 || a1) nacc++;
      cyc++;
    end
    if (stop_acc == 0) begin bus.s0_valid = 1'b0; bus.s1_valid = 1'b0; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_rr = 1'b0;
    sq0.delete(); sq1.delete(); fq0.delete(); fq1.delete();
    repeat (REARM + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    bit seq[4];
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.fft_rst_n, bus.m_valid, bus.busy, bus.err_timeout, bus.fft_in_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got rstn/mv/busy/err/inv=%b want 00000",
               {bus.fft_rst_n, bus.m_valid, bus.busy, bus.err_timeout, bus.fft_in_valid});
    end
    rst = 1'b0;
    #1 seq[0] = bus.fft_rst_n;
    for (int c = 1; c < 4; c++) begin @(negedge clk); seq[c] = bus.fft_rst_n; end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (seq[c] !== (c >= REARM)) begin
        errors++;
        $display("FAIL rearm_after_reset cycle %0d fft_rst_n got %b want %b", c, seq[c], c >= REARM);
      end
    end
    checks++;
    if ({bus.busy, bus.s0_ready, bus.s1_ready} !== 3'b000) begin
      errors++;
      $display("FAIL idle_state busy/r0/r1 got %b want 000", {bus.busy, bus.s0_ready, bus.s1_ready});
    end
  endtask

  task automatic test_single_frame();
    int ninv = 0;
    int l = -1;
    load(0, 1, 1'b1);
    build_expected();
    run(500);
    checks++;
    if (timed_out) begin errors++; $display("FAIL single_frame_bound got timeout want done"); end
    foreach (tr_inval[c]) if (tr_inval[c]) ninv++;
    checks++;
    if (ninv != N) begin errors++; $display("FAIL single_in_valid got %0d want %0d", ninv, N); end
    checks++;
    if (out_q.size() != N) begin
      errors++; $display("FAIL single_out_count got %0d want %0d", out_q.size(), N);
    end
    for (int k = 0; k < N && k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== out_t'{r: (k == 0) ? 16'sd3200 : 16'sd0, i: 16'sd0, src: 1'b0,
                              idx: IW'(k), last: (k == N - 1)}) begin
        errors++;
        $display("FAIL single_bin%0d got r=%0d i=%0d src=%0d idx=%0d last=%0d want r=%0d", k,
                 out_q[k].r, out_q[k].i, out_q[k].src, out_q[k].idx, out_q[k].last,
                 (k == 0) ? 3200 : 0);
      end
    end
    foreach (tr_last[c]) if (tr_last[c] && l < 0) l = c;
    checks++;
    if (l < 0 || l + 2 >= tr_rstn.size() ||
        {tr_rstn[l], tr_rstn[l+1], tr_rstn[l+2]} !== 3'b001) begin
      errors++; $display("FAIL single_rearm_pulse last_at=%0d want rstn 0,0,1 after last", l);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    do_reset();
    load(0, 2, 1'b0);
    load(1, 1, 1'b0);
    build_expected();
    run(2000);
    checks++;
    if (timed_out || out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_out_count got %0d want %0d", out_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < out_q.size(); j++) begin
      checks++;
      if (out_q[j] !== exp_q[j]) begin
        errors++;
        $display("FAIL b2b_out%0d got r=%0d i=%0d src=%0d idx=%0d want r=%0d i=%0d src=%0d idx=%0d",
                 j, out_q[j].r, out_q[j].i, out_q[j].src, out_q[j].idx,
                 exp_q[j].r, exp_q[j].i, exp_q[j].src, exp_q[j].idx);
      end
    end
    if (out_q.size() == 3 * N) begin
      checks++;
      if ({out_q[0].src, out_q[N].src, out_q[2*N].src} !== 3'b010) begin
        errors++;
        $display("FAIL b2b_src_order got %b%b%b want 010", out_q[0].src, out_q[N].src,
                 out_q[2*N].src);
      end
    end
    foreach (exp_acc[j]) if (j >= acc_src_q.size() || acc_src_q[j] != exp_acc[j]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_accept_order got %0d wrong want 0", bad); end
  endtask

  task automatic test_gaps();
    int ninv = 0, bad = 0, first = -1, lastv = -1, first_mv = -1;
    gap_every = 3;
    load(1, 1, 1'b0);
    build_expected();
    run(800);
    gap_every = 0;
    foreach (tr_inval[c]) if (tr_inval[c]) begin
      ninv++; lastv = c; if (first < 0) first = c;
    end
    foreach (tr_mv[c]) if (tr_mv[c] && first_mv < 0) first_mv = c;
    for (int c = 0; c + 1 < tr_inval.size() && c < tr_acc.size(); c++)
      if (tr_inval[c+1] != tr_acc[c]) bad++;
    checks++;
    if (timed_out || ninv != N) begin
      errors++; $display("FAIL gap_in_valid_count got %0d want %0d", ninv, N);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL gap_in_valid_track got %0d diffs want 0", bad); end
    checks++;
    if (lastv - first + 1 <= N) begin
      errors++; $display("FAIL gap_spread got %0d cycles want >%0d", lastv - first + 1, N);
    end
    checks++;
    if (first_mv <= lastv) begin
      errors++; $display("FAIL gap_drain_order got first m_valid %0d want >%0d", first_mv, lastv);
    end
    checks++;
    if (out_q.size() != N || out_q !== exp_q) begin
      errors++; $display("FAIL gap_results got %0d samples want %0d matching", out_q.size(), N);
    end
  endtask

  task automatic test_timeout();
    int last_acc = -1, rise = -1;
    core_hang = 1'b1;
    load(0, 1, 1'b0);
    build_expected();
    run(1500);
    core_hang = 1'b0;
    foreach (tr_acc[c]) if (tr_acc[c]) last_acc = c;
    foreach (tr_err[c]) if (tr_err[c] && rise < 0) rise = c;
    checks++;
    if (timed_out || out_q.size() != 0) begin
      errors++; $display("FAIL timeout_no_output got %0d samples want 0", out_q.size());
    end
    checks++;
    if (rise - last_acc != TMO + 1) begin
      errors++; $display("FAIL timeout_delay got %0d want %0d", rise - last_acc, TMO + 1);
    end
    checks++;
    if (rise < 0 || tr_rstn[rise] !== 1'b0) begin
      errors++; $display("FAIL timeout_rearm got rstn=%b want 0", (rise < 0) ? 1'b1 : tr_rstn[rise]);
    end
    load(0, 1, 1'b0);
    build_expected();
    run(500);
    checks++;
    if (timed_out || out_q !== exp_q) begin
      errors++; $display("FAIL timeout_next_frame got %0d samples want %0d", out_q.size(), N);
    end
    checks++;
    if (bus.err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky got %b want 1", bus.err_timeout);
    end
  endtask

  task automatic test_reset_midframe();
    load(0, 1, 1'b0);
    load(1, 1, 1'b0);
    stop_acc = 17;
    run(300);
    stop_acc = 0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.fft_rst_n, bus.m_valid, bus.busy, dut.u_arb.rr_ptr_q} !== 4'b0000) begin
      errors++;
      $display("FAIL midframe_reset got rstn/mv/busy/rr=%b want 0000",
               {bus.fft_rst_n, bus.m_valid, bus.busy, dut.u_arb.rr_ptr_q});
    end
    checks++;
    if (timed_out || out_q.size() != 0) begin
      errors++; $display("FAIL midframe_partial got %0d samples want 0", out_q.size());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rr = 1'b0;
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    sq0.delete(); sq1.delete(); fq0.delete(); fq1.delete();
    load(0, 1, 1'b0);
    load(1, 1, 1'b0);
    build_expected();
    run(1500);
    checks++;
    if (acc_src_q.size() == 0 || acc_src_q[0] != 0) begin
      errors++;
      $display("FAIL midframe_first_grant got %0d want 0",
               (acc_src_q.size() == 0) ? -1 : acc_src_q[0]);
    end
    checks++;
    if (timed_out || out_q !== exp_q) begin
      errors++; $display("FAIL midframe_next_frames got %0d samples want %0d", out_q.size(), 2 * N);
    end
  endtask

  initial begin
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    bus.s0_r = '0; bus.s0_i = '0; bus.s1_r = '0; bus.s1_i = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gaps();
    test_timeout();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
